// File: rtl/multicycle_control_if.sv
// Bundle of the control unit's opcode/handshake inputs and datapath control outputs.
// master: the control unit; slave: the datapath/memory side.
interface multicycle_control_if #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
);
    logic [5:0]         OPcode;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               BranchNe;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         PCSource;
    logic               instr_done;
    logic               illegal_op;
    logic               bus_err;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  OPcode, mem_ready,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, bus_err, retired
    );

    modport slave (
        output OPcode, mem_ready,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, bus_err, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences each instruction, stalls on mem_ready with a
// timeout, flags illegal opcodes and counts retired instructions.
module multicycle_control #(
    parameter int ALUOP_W     = 2,
    parameter int IMM_EN      = 1,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
        S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_IMM   = ALUOP_W'(3);
    localparam logic [7:0]         TMO_LAST  = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_wait;
    logic             instr_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    assign mem_wait   = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                        && !bus.mem_ready;
    assign instr_done = (state_q == S_MEMWB) || (state_q == S_RWB) || (state_q == S_IWB) ||
                        (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                        ((state_q == S_MEMWR) && bus.mem_ready);

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retired_d = retired_q + CNT_W'(instr_done);
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.OPcode)
                    OP_RTYPE:      state_d = S_REXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                        if (IMM_EN != 0) begin
                            state_d = S_IEXEC;
                        end else begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // sw differs from lw only in OPcode[3]
            S_MEMADR: state_d = bus.OPcode[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
        // Stall watchdog: the counter only survives consecutive waiting cycles.
        if (mem_wait) begin
            if (tmo_q >= TMO_LAST) begin
                state_d   = S_HALT;
                bus_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end
    end

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = ALU_ADD;
        bus.PCSource    = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            S_DECODE: bus.ALUSrcB = 2'b11;
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_REXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = ALU_IMM;
            end
            S_IWB: bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BranchNe    = bus.OPcode[0];
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.instr_done = instr_done;
    assign bus.illegal_op = illegal_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, randomized instruction stream against
// a per-instruction cost model, and hand-written reset/timeout/illegal/wrap sequences.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    longint exp_retired = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_W(2), .CNT_W(32)) bus ();
    multicycle_control_if #(.ALUOP_W(2), .CNT_W(4))  bus2 ();

    multicycle_control #(.ALUOP_W(2), .IMM_EN(1), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    multicycle_control #(.ALUOP_W(2), .IMM_EN(0), .MEM_TIMEOUT(15), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2)
    );

    // Per-instruction observation (or expectation) record.
    typedef struct {
        logic [5:0] op;
        int fw;       // mem_ready-low cycles during fetch
        int mw;       // mem_ready-low cycles during data access
        int cycles;   // cycles from FETCH to retire, inclusive
        int rw_cycle; // cycle with RegWrite=1 (0: none)
        int regdst;
        int memtoreg;
        int pcwc;     // PCWriteCond at retire cycle
        int bne;      // BranchNe at retire cycle
        int aluop;    // ALUOp at retire cycle
        int pcsrc;    // PCSource at retire cycle
        int mr;       // cycles with MemRead=1
        int mwr;      // cycles with MemWrite=1
        int pcwr;     // cycles with PCWrite=1
        int irwr;     // cycles with IRWrite=1
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int any_ctrl(input bit second);
        if (!second)
            return int'(bus.PCWrite | bus.PCWriteCond | bus.BranchNe | bus.IorD | bus.MemRead |
                        bus.MemWrite | bus.IRWrite | bus.MemtoReg | bus.RegDst | bus.RegWrite |
                        bus.ALUSrcA | (|bus.ALUSrcB) | (|bus.ALUOp) | (|bus.PCSource) | bus.instr_done);
        return int'(bus2.PCWrite | bus2.PCWriteCond | bus2.BranchNe | bus2.IorD | bus2.MemRead |
                    bus2.MemWrite | bus2.IRWrite | bus2.MemtoReg | bus2.RegDst | bus2.RegWrite |
                    bus2.ALUSrcA | (|bus2.ALUSrcB) | (|bus2.ALUOp) | (|bus2.PCSource) | bus2.instr_done);
    endfunction

    // Everything except the two outputs a freshly reset FETCH drives high.
    function automatic int any_other();
        return int'(bus.PCWrite | bus.PCWriteCond | bus.BranchNe | bus.IorD | bus.MemWrite |
                    bus.IRWrite | bus.MemtoReg | bus.RegDst | bus.RegWrite | bus.ALUSrcA |
                    (|bus.ALUOp) | (|bus.PCSource) | bus.instr_done);
    endfunction

    // Reference model: cost and visible effects of one instruction by instruction class.
    function automatic vec_t model(input logic [5:0] op, input int fw, input int mw);
        vec_t e = '{default: 0};
        e.op = op; e.fw = fw; e.mw = mw;
        e.mr = fw + 1; e.pcwr = 1; e.irwr = 1;
        case (op)
            6'b000000: begin e.cycles = 4 + fw; e.rw_cycle = e.cycles; e.regdst = 1; end
            6'b100011: begin
                e.cycles = 5 + fw + mw; e.rw_cycle = e.cycles; e.memtoreg = 1;
                e.mr = e.mr + mw + 1;
            end
            6'b101011: begin e.cycles = 4 + fw + mw; e.mwr = mw + 1; end
            6'b000100, 6'b000101: begin
                e.cycles = 3 + fw; e.pcwc = 1; e.bne = (op == 6'b000101) ? 1 : 0;
                e.aluop = 1; e.pcsrc = 1;
            end
            6'b000010: begin e.cycles = 3 + fw; e.pcsrc = 2; e.pcwr = 2; end
            default:   begin e.cycles = 4 + fw; e.rw_cycle = e.cycles; end
        endcase
        return e;
    endfunction

    // Runs one instruction with a reactive memory that stalls fw / mw cycles per access.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, output vec_t r);
        int  wl = fw;
        bit  done = 0;
        r = '{default: 0};
        r.op = op; r.fw = fw; r.mw = mw;
        bus.OPcode = op;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clk);
            if (bus.MemRead || bus.MemWrite) begin
                if (wl > 0) begin bus.mem_ready = 1'b0; wl--; end
                else begin bus.mem_ready = 1'b1; wl = mw; end
            end else begin
                bus.mem_ready = 1'($urandom);
            end
            #1;
            r.cycles = c;
            r.mr   += int'(bus.MemRead);
            r.mwr  += int'(bus.MemWrite);
            r.pcwr += int'(bus.PCWrite);
            r.irwr += int'(bus.IRWrite);
            if (bus.RegWrite && r.rw_cycle == 0) begin
                r.rw_cycle = c; r.regdst = int'(bus.RegDst); r.memtoreg = int'(bus.MemtoReg);
            end
            if (bus.instr_done) begin
                done = 1;
                r.pcwc = int'(bus.PCWriteCond); r.bne = int'(bus.BranchNe);
                r.aluop = int'(bus.ALUOp); r.pcsrc = int'(bus.PCSource);
            end
        end
        if (!done) r.cycles = -1;
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input vec_t e, input vec_t r);
        $display("%s op=%b fw=%0d mw=%0d cycles=%0d retired=%0d", tag, r.op, r.fw, r.mw,
                 r.cycles, bus.retired);
        chk({tag, "_cycles"}, r.cycles, e.cycles);
        chk({tag, "_regwr_cycle"}, r.rw_cycle, e.rw_cycle);
        chk({tag, "_regdst"}, r.regdst, e.regdst);
        chk({tag, "_memtoreg"}, r.memtoreg, e.memtoreg);
        chk({tag, "_pcwritecond"}, r.pcwc, e.pcwc);
        chk({tag, "_branchne"}, r.bne, e.bne);
        chk({tag, "_aluop"}, r.aluop, e.aluop);
        chk({tag, "_pcsource"}, r.pcsrc, e.pcsrc);
        chk({tag, "_memread_cyc"}, r.mr, e.mr);
        chk({tag, "_memwrite_cyc"}, r.mwr, e.mwr);
        chk({tag, "_pcwrite_cyc"}, r.pcwr, e.pcwr);
        chk({tag, "_irwrite_cyc"}, r.irwr, e.irwr);
        exp_retired++;
        chk({tag, "_retired"}, bus.retired, exp_retired);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_retired = 0;
    endtask

    vec_t tbl[12];
    logic [5:0] legal_ops[10];

    initial begin
        vec_t r;
        int   n_mr;
        bit   hit;

        tbl[0]  = '{6'b000000, 0, 0,  4,  4, 1, 0, 0, 0, 0, 0,  1, 0, 1, 1};
        tbl[1]  = '{6'b100011, 0, 3,  8,  8, 0, 1, 0, 0, 0, 0,  5, 0, 1, 1};
        tbl[2]  = '{6'b101011, 0, 0,  4,  0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1};
        tbl[3]  = '{6'b000100, 0, 0,  3,  0, 0, 0, 1, 0, 1, 1,  1, 0, 1, 1};
        tbl[4]  = '{6'b000101, 2, 0,  5,  0, 0, 0, 1, 1, 1, 1,  3, 0, 1, 1};
        tbl[5]  = '{6'b000010, 0, 0,  3,  0, 0, 0, 0, 0, 0, 2,  1, 0, 2, 1};
        tbl[6]  = '{6'b001000, 0, 0,  4,  4, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1};
        tbl[7]  = '{6'b001010, 1, 0,  5,  5, 0, 0, 0, 0, 0, 0,  2, 0, 1, 1};
        tbl[8]  = '{6'b101011, 1, 2,  7,  0, 0, 0, 0, 0, 0, 0,  2, 3, 1, 1};
        tbl[9]  = '{6'b100011, 14, 14, 33, 33, 0, 1, 0, 0, 0, 0, 30, 0, 1, 1};
        tbl[10] = '{6'b001101, 0, 0,  4,  4, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1};
        tbl[11] = '{6'b001100, 0, 0,  4,  4, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1};
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                      6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

        bus.OPcode = 6'b000000;
        bus.mem_ready = 1'b0;
        bus2.OPcode = 6'b000010;
        bus2.mem_ready = 1'b1;

        // Reset state, then fetch stall until the watchdog fires.
        do_reset();
        chk("rst_memread", bus.MemRead, 1);
        chk("rst_alusrcb", bus.ALUSrcB, 1);
        chk("rst_others", any_other(), 0);
        chk("rst_retired", bus.retired, 0);
        chk("rst_errors", {bus.illegal_op, bus.bus_err}, 0);
        n_mr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            n_mr += int'(bus.MemRead);
        end
        $display("timeout memread_cycles=%0d bus_err=%0d", n_mr, bus.bus_err);
        chk("tmo_memread_cycles", n_mr, 15);
        chk("tmo_bus_err", bus.bus_err, 1);
        chk("tmo_memread_after", bus.MemRead, 0);
        chk("tmo_all_ctrl", any_ctrl(0), 0);
        chk("tmo_illegal", bus.illegal_op, 0);

        do_reset();
        chk("rst2_bus_err_clr", bus.bus_err, 0);
        chk("rst2_memread", bus.MemRead, 1);

        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, r);
            compare($sformatf("vec%0d", i), tbl[i], r);
        end

        for (int i = 0; i < 40; i++) begin
            logic [5:0] op = legal_ops[$urandom_range(0, 9)];
            int fw = $urandom_range(0, 4);
            int mw = $urandom_range(0, 4);
            run_instr(op, fw, mw, r);
            compare($sformatf("rnd%0d", i), model(op, fw, mw), r);
        end

        // Reset while a store is waiting: aborted without retiring.
        bus.OPcode = 6'b101011;
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.MemWrite) begin
                hit = 1;
                bus.mem_ready = 1'b0;
                rst_n = 1'b0;
                break;
            end
            bus.mem_ready = 1'b1;
        end
        chk("memwr_reached", hit, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_retired = 0;
        $display("reset_in_memwr memwrite=%0d memread=%0d retired=%0d", bus.MemWrite, bus.MemRead, bus.retired);
        chk("abort_memwrite", bus.MemWrite, 0);
        chk("abort_memread", bus.MemRead, 1);
        chk("abort_retired", bus.retired, 0);
        chk("abort_done", bus.instr_done, 0);
        chk("abort_regwrite", bus.RegWrite, 0);

        // Illegal opcode halts until reset.
        bus.OPcode = 6'b111111;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.mem_ready = 1'($urandom);
            #1;
            chk($sformatf("halt_ctrl%0d", c), any_ctrl(0), 0);
        end
        $display("illegal illegal_op=%0d bus_err=%0d retired=%0d", bus.illegal_op, bus.bus_err, bus.retired);
        chk("halt_illegal", bus.illegal_op, 1);
        chk("halt_bus_err", bus.bus_err, 0);
        chk("halt_retired", bus.retired, 0);
        do_reset();
        chk("rst3_illegal_clr", bus.illegal_op, 0);

        // Second instance: 4-bit counter wrap on back-to-back jumps, then imm opcode illegal.
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        chk("wrap_before", bus2.retired, 15);
        repeat (3) @(posedge clk);
        #1;
        $display("wrap retired=%0d", bus2.retired);
        chk("wrap_after", bus2.retired, 0);
        bus2.OPcode = 6'b001000;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus2.mem_ready = 1'($urandom);
            #1;
            chk($sformatf("noimm_ctrl%0d", c), any_ctrl(1), 0);
        end
        $display("noimm illegal_op=%0d retired=%0d", bus2.illegal_op, bus2.retired);
        chk("noimm_illegal", bus2.illegal_op, 1);
        chk("noimm_retired", bus2.retired, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
